// File: rtl/systolic_pkg.sv
// Shared constants and state type for the systolic-array processing element.
package systolic_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StAcc  = 1'b1
  } pe_state_e;

endpackage

// File: rtl/multiplier_top8.sv
// Combinational 8x8 signed radix-4 Booth multiplier feeding the PE product register.
module multiplier_top8
  import systolic_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [PROD_W-1:0] prod_o
);

  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] pp;
  logic signed [PROD_W-1:0] acc;
  logic        [DATA_W:0]   bx;

  assign a_ext = PROD_W'($signed(a_i));
  // Implicit zero below the LSB so the first Booth triple sees b[1:0] and a 0.
  assign bx    = {b_i, 1'b0};

  always_comb begin
    acc = '0;
    pp  = '0;
    for (int i = 0; i < DATA_W / 2; i++) begin
      case (bx[2*i +: 3])
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      acc = acc + (pp <<< (2 * i));
    end
  end

  assign prod_o = acc;

endmodule

// File: rtl/systolic_mac_pe.sv
// Output-stationary systolic PE: operand forwarding, registered Booth product and
// per-tile signed accumulation with a one-cycle result pulse.
module systolic_mac_pe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              fwd_valid,
  output logic              fwd_first,
  output logic              fwd_last,
  output logic              res_valid,
  output logic [ACC_W-1:0]  res_data,
  output logic              res_ovf,
  output logic              err_proto
);
  import systolic_pkg::*;

  // Stage 1: operand and flag capture, also the forwarding outputs.
  logic [DATA_W-1:0] a_q, b_q;
  logic              v1_q, f1_q, l1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      v1_q <= 1'b0;
      f1_q <= 1'b0;
      l1_q <= 1'b0;
    end else begin
      a_q  <= a_in;
      b_q  <= b_in;
      v1_q <= in_valid;
      f1_q <= in_first;
      l1_q <= in_last;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign fwd_valid = v1_q;
  assign fwd_first = f1_q;
  assign fwd_last  = l1_q;

  // Stage 2: product register.
  logic [PROD_W-1:0]        prod;
  logic signed [PROD_W-1:0] p_q;
  logic                     v2_q, f2_q, l2_q;

  multiplier_top8 u_mult (
    .a_i    (a_q),
    .b_i    (b_q),
    .prod_o (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q  <= '0;
      v2_q <= 1'b0;
      f2_q <= 1'b0;
      l2_q <= 1'b0;
    end else begin
      p_q  <= prod;
      v2_q <= v1_q;
      f2_q <= f1_q;
      l2_q <= l1_q;
    end
  end

  // Stage 3: tile accumulation FSM.
  pe_state_e               state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, p_ext, sum;
  logic                    ovf_q, ovf_d;
  logic [ACC_W-1:0]        res_data_q, res_data_d;
  logic                    res_ovf_q, res_ovf_d;
  logic                    res_valid_q, res_valid_d;
  logic                    err_q, err_d;
  logic                    take;

  assign p_ext = ACC_W'(p_q);
  assign sum   = acc_q + p_ext;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    take        = 1'b0;
    if (v2_q) begin
      if (f2_q) begin
        // A first beat mid-tile abandons the partial sum and restarts.
        err_d = (state_q == StAcc);
        acc_d = p_ext;
        ovf_d = 1'b0;
        take  = 1'b1;
      end else if (state_q == StAcc) begin
        acc_d = sum;
        ovf_d = ovf_q | ((acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]));
        take  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      if (take) begin
        if (l2_q) begin
          res_data_d  = acc_d;
          res_ovf_d   = ovf_d;
          res_valid_d = 1'b1;
          state_d     = StIdle;
        end else begin
          state_d = StAcc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign err_proto = err_q;

endmodule

// File: doc/systolic_mac_pe.md
# systolic_mac_pe

Output-stationary processing element for the systolic array. Sits directly downstream of the 8x8 Booth multiplier: registers its operands, forwards them to the east and south neighbours, registers the 16-bit product and accumulates products of one tile into a wide signed accumulator. At the end of each tile it presents the result with a one-cycle valid pulse.

## Interface
- `DATA_W`, default 8: operand width. Fixed at 8 to match `multiplier_top8`.
- `ACC_W`, default 32: accumulator and result width. Must be at least 16.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `in_valid` input, 1 bit: a beat is present on `a_in`/`b_in`.
- `in_first` input, 1 bit: the beat is the first beat of a tile. Qualified by `in_valid`.
- `in_last` input, 1 bit: the beat is the last beat of a tile. Qualified by `in_valid`.
- `a_in` input, 8 bits: signed two's-complement operand from the west.
- `b_in` input, 8 bits: signed two's-complement operand from the north.
- `a_out` output, 8 bits: registered `a_in`, to the east neighbour.
- `b_out` output, 8 bits: registered `b_in`, to the south neighbour.
- `fwd_valid`, `fwd_first`, `fwd_last` outputs, 1 bit each: registered copies of `in_valid`, `in_first` and `in_last`.
- `res_valid` output, 1 bit: one-cycle pulse when a tile result is presented.
- `res_data` output, `ACC_W` bits: signed tile sum. Held until the next result.
- `res_ovf` output, 1 bit: signed overflow occurred during the tile. Held with `res_data`.
- `err_proto` output, 1 bit: one-cycle pulse on a framing error.

## Operation
- **Stage 1.** On an edge, `a_in`, `b_in`, `in_valid`, `in_first` and `in_last` are captured into `a_r`, `b_r`, `v1`, `f1` and `l1`.
  - These registers drive the forwarding outputs directly.
  - The flags are captured as given; when `in_valid` is 0 they have no meaning.
- **Stage 2.** `multiplier_top8(a_r, b_r)` is combinational. Its 16-bit signed result is registered into `p_r` together with `v2`, `f2` and `l2`.
- **Stage 3, accumulate.** The FSM has two states:
  - **IDLE** (reset state).
  - **ACC**.
- **Stage 3 transitions.** Actions on beats with `v2` = 1:
  - IDLE with `f2` = 1: `acc` ← sign-extended `p_r`; `ovf` ← 0. Go to ACC, or stay in IDLE if `l2` is also 1.
  - IDLE with `f2` = 0: beat dropped, `err_proto` pulses, `acc` is unchanged.
  - ACC with `f2` = 0: `acc` ← `acc` + sign-extended `p_r`, wrapping modulo 2^ACC_W. `ovf` is set, sticky, when the operands have equal signs and the sum sign differs.
  - ACC with `f2` = 1: the partial tile is abandoned, `err_proto` pulses, and the tile restarts exactly as the IDLE+first case.
  - Any beat with `l2` = 1: `res_data` ← new `acc`, `res_ovf` ← new `ovf`, `res_valid` pulses, and the FSM returns to IDLE.
  - A beat with `f2` = 1 and `l2` = 1 forms a one-beat tile: result = product.
- **Bubbles.** A `v2` = 0 cycle changes nothing in stage 3.
- **Reset.** Asynchronous `rst` clears every register:
  - All outputs go to 0.
  - The FSM goes to IDLE.
  - Any in-flight tile and any beats still in the pipeline are discarded; no result is produced for them.

## Timing
- Forwarding latency is 1 cycle: a beat at edge N appears on `a_out`/`b_out`/`fwd_*` after edge N.
- Result latency is 3 edges from sampling of the last beat. The last beat is sampled at edge N; `res_valid` is high for the cycle after edge N+2.
- Throughput is one beat per cycle. There is no backpressure.
- Back-to-back tiles are allowed: a last beat followed by a first beat on the next cycle gives no gap and no error.
- `res_data` changes only when `res_valid` pulses.
- `err_proto` pulses in the same cycle as the stage-3 action that causes it.

## Structure
- Package `systolic_pkg` holds:
  - the constants `DATA_W` = 8 and `PROD_W` = 16;
  - the PE state enum, with IDLE and ACC.
- The only sub-module is one `multiplier_top8` instance between stage 1 and stage 2.
- Forwarding registers, pipeline registers and the FSM stay in this module.

## Test plan
- **Reset.** Assert `rst` mid-cycle with non-zero inputs.
  - Required: all outputs are 0 immediately, without waiting for a clock edge.
  - After release, the first tile is correct.
- **4-beat tile.** Beats (3,5), (−2,7), (127,127), (−128,−128), first on beat 1, last on beat 4.
  - Required: `res_data` = 32514 and `res_ovf` = 0.
  - Required: `res_valid` high only in the cycle after the third edge following the last beat.
- **Forwarding.** `a_in` = 0x5A, `b_in` = 0xA5 and `in_valid` = 1 at edge N.
  - Required: `a_out` = 0x5A, `b_out` = 0xA5 and `fwd_valid` = 1 after edge N; they return to the new inputs after edge N+1.
- **One-beat tile.** Single beat (−1,−1) with first = last = 1.
  - Required: `res_data` = 1.
- **Bubbles between tiles.** Idle cycles inserted between the beats of the 4-beat tile.
  - Required: the result is unchanged.
- **Overflow, `ACC_W` = 16.** Three beats of (127,127).
  - Required: `res_data` = −17149 (0xBD03) and `res_ovf` = 1.
  - Required: the next tile (2,2) gives 4 with `res_ovf` = 0.
- **Protocol errors and reset mid-tile.**
  - Beat without first while IDLE: `err_proto` pulses and there is no result.
  - First beat in mid-tile with (1,1) first, (1,1), then first (2,3) last: `err_proto` pulses once and `res_data` = 6.
  - `rst` pulse after 2 beats of a tile: no `res_valid` for that tile.
